// File: rtl/mips_pkg.sv
// Shared datapath types: pipeline beat layout, skid-buffer states, select-width helper.
// Module-local beat structs reuse this layout at their own WIDTH/SEL_W.
package mips_pkg;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_NUM_INPUTS = 4;
  localparam int DEF_SEL_W      = sel_width(DEF_NUM_INPUTS);

  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic [DEF_SEL_W-1:0] sel;
    logic                 err;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/mux_nx1_comb.sv
// Combinational N:1 word selector; zero latency, no state, no flow control.
// Selects at or above NUM_INPUTS yield all-zero data with bad=1.
module mux_nx1_comb
  import mips_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int NUM_INPUTS = 4,
  localparam int SEL_W      = sel_width(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]            sel,
  output logic [WIDTH-1:0]            data,
  output logic                        bad
);

  always_comb begin
    data = '0;
    bad  = 1'b1;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (sel == SEL_W'(k)) begin
        data = in_data[k*WIDTH +: WIDTH];
        bad  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_select_pipe.sv
// Registered N:1 selector with valid/ready and a 2-entry skid buffer; 1-cycle latency.
// in_ready depends only on state (low in FULL), so out_ready never reaches in_ready combinationally.
module mux_select_pipe
  import mips_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int NUM_INPUTS = 4,
  parameter  int ERR_CNT_W  = 8,
  localparam int SEL_W      = sel_width(NUM_INPUTS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [SEL_W-1:0]            out_sel,
  output logic                        out_err,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ERR_CNT_W-1:0]        err_count,
  input  logic                        err_clear
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } pipe_beat_t;

  state_t     state, state_nxt;
  pipe_beat_t main_q, skid_q, cap;
  logic [WIDTH-1:0] mux_data;
  logic       mux_bad;
  logic       accept, xfer;
  logic       load_main_in, load_main_skid, load_skid;

  mux_nx1_comb #(
    .WIDTH      (WIDTH),
    .NUM_INPUTS (NUM_INPUTS)
  ) u_mux (
    .in_data (in_data),
    .sel     (in_sel),
    .data    (mux_data),
    .bad     (mux_bad)
  );

  assign cap       = '{data: mux_data, sel: in_sel, err: mux_bad};
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  assign out_data  = main_q.data;
  assign out_sel   = main_q.sel;
  assign out_err   = main_q.err;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_nxt    = ONE;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (xfer) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (xfer) begin
          load_main_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      err_count <= '0;
    end else begin
      state <= state_nxt;
      if (load_main_in) begin
        main_q <= cap;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= cap;
      end
      // Clear takes priority over a same-cycle bad-beat increment.
      if (err_clear) begin
        err_count <= '0;
      end else if (accept && cap.err && (err_count != '1)) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux_select_pipe.sv
// Scoreboard bench for mux_select_pipe (WIDTH=32, NUM_INPUTS=3 so select 3 is out of range).
module tb_mux_select_pipe;

  localparam int W  = 32;
  localparam int NI = 3;
  localparam int SW = 2;
  localparam int CW = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [NI*W-1:0] in_data;
  logic [SW-1:0]  in_sel;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_err;
  logic           out_valid;
  logic           out_ready;
  logic [CW-1:0]  err_count;
  logic           err_clear;

  mux_select_pipe #(.WIDTH(W), .NUM_INPUTS(NI), .ERR_CNT_W(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_count (err_count),
    .err_clear (err_clear)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] sel;
    logic          err;
  } exp_t;

  exp_t q[$];
  int   ncheck = 0;
  int   npass  = 0;
  int   acc    = 0;
  int   errm   = 0;
  logic stall_prev = 1'b0;
  exp_t prev_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncheck++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: the selected word for an in-range select, zero plus error flag otherwise.
  function automatic exp_t model(input logic [NI*W-1:0] d, input logic [SW-1:0] s);
    exp_t e;
    e.sel = s;
    if (int'(s) < NI) begin
      e.data = d[int'(s)*W +: W];
      e.err  = 1'b0;
    end else begin
      e.data = '0;
      e.err  = 1'b1;
    end
    return e;
  endfunction

  // Monitor/scoreboard: queue holds exactly the beats the DUT should be holding.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      errm       = 0;
      stall_prev = 1'b0;
    end else begin
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, q.size() < 2);
      chk("err_count", err_count, errm);
      if (stall_prev)
        chk("stable_under_stall", {out_data, out_sel, out_err}, prev_out);
      if (out_valid && q.size() != 0) begin
        chk("out_data", out_data, q[0].data);
        chk("out_sel", out_sel, q[0].sel);
        chk("out_err", out_err, q[0].err);
        if (out_ready) void'(q.pop_front());
      end
      stall_prev = out_valid && !out_ready;
      prev_out   = '{data: out_data, sel: out_sel, err: out_err};
      if (in_valid && in_ready) begin
        q.push_back(model(in_data, in_sel));
        acc++;
      end
      if (err_clear) errm = 0;
      else if (in_valid && in_ready && int'(in_sel) >= NI && errm < 255) errm++;
    end
  end

  task automatic cyc(input logic v, input logic [SW-1:0] s, input logic r, input logic c);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_sel    = s;
    out_ready = r;
    err_clear = c;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    out_ready = 1'b0;
    err_clear = 1'b0;
    in_data   = {32'h33333333, 32'h22222222, 32'h11111111};
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_in_ready", in_ready, 1);

    // Back-to-back streaming with the consumer always ready.
    cyc(1, 0, 1, 0); cyc(1, 1, 1, 0); cyc(1, 2, 1, 0); cyc(1, 0, 1, 0);
    cyc(0, 0, 1, 0);
    @(negedge clk);
    chk("stream_last_data", out_data, 32'h11111111);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);

    // Stall: second accept lands in the skid register.
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_hold_data", out_data, 32'h22222222);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    @(negedge clk);
    chk("drain_second_data", out_data, 32'h33333333);
    chk("drain_in_ready", in_ready, 1);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);

    // Out-of-range select.
    cyc(1, 3, 1, 0); cyc(0, 0, 1, 0);
    @(negedge clk);
    chk("bad_data", out_data, 0);
    chk("bad_err", out_err, 1);
    chk("bad_count", err_count, 1);
    for (int i = 0; i < 300; i++) cyc(1, 3, 1, 0);
    cyc(0, 0, 1, 0);
    @(negedge clk);
    chk("err_saturated", err_count, 255);
    cyc(1, 3, 1, 1); cyc(0, 0, 1, 0);
    @(negedge clk);
    chk("err_clear_wins", err_count, 0);
    cyc(1, 3, 1, 0);

    // Reset while FULL: skid beat must never appear.
    cyc(1, 0, 0, 0); cyc(1, 1, 0, 0); cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("pre_reset_full", in_ready, 0);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_sel", out_sel, 0);
    chk("mid_rst_out_err", out_err, 0);
    chk("mid_rst_err_count", err_count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (3) cyc(0, 0, 1, 0);

    // Random traffic, bounded by a cycle budget.
    acc = 0;
    for (int n = 0; n < 60000 && acc < 10000; n++) begin
      @(posedge clk);
      #1;
      in_valid  = $urandom_range(0, 1);
      in_sel    = SW'($urandom_range(0, 3));
      out_ready = $urandom_range(0, 1);
      err_clear = ($urandom_range(0, 63) == 0);
      in_data   = {$urandom, $urandom, $urandom};
    end
    chk("random_beats_done", acc >= 10000, 1);
    repeat (4) cyc(0, 0, 1, 0);
    @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule
